// File: rtl/demux_1x16.sv
`default_nettype none
// ============================================================================
// Module      : demux_1x16
// Description : 1-to-16 valid/ready demultiplexer. Each output lane owns a
//               single-entry skid register (payload + full flag). An input
//               beat is steered to the lane named by in_sel and appears on
//               that lane one cycle after acceptance. Lanes drain
//               independently, and a lane may be drained and reloaded on the
//               same edge so a busy lane runs at full throughput.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_1x16 #(
    parameter int DW = 32
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           in_sel,
    input  logic [DW-1:0]        in_data,

    output logic [15:0]          out_valid,
    input  logic [15:0]          out_ready,
    output logic [16*DW-1:0]     out_data,

    output logic                 busy,
    output logic [15:0]          beat_cnt
);

    localparam int c_LANES = 16;

    // Per-lane storage: full flags and payload registers, lane k in row k.
    logic [c_LANES-1:0]         r_full;
    logic [c_LANES-1:0][DW-1:0] r_data;
    logic [15:0]                r_beat_cnt;

    logic                       w_sel_full;
    logic                       w_sel_drain;
    logic                       w_accept;
    logic [c_LANES-1:0]         w_load;

    // Only the addressed lane decides backpressure; a lane that is being
    // drained this edge can take a new beat on the same edge.
    assign w_sel_full  = r_full[in_sel];
    assign w_sel_drain = out_ready[in_sel];
    assign in_ready    = !rst && (!w_sel_full || w_sel_drain);
    assign w_accept    = in_valid && in_ready;

    // One-hot load strobe for the lane receiving the accepted beat.
    assign w_load      = w_accept ? (c_LANES'(1) << in_sel) : '0;

    // Lane registers: a load wins over a drain so a same-edge drain+load
    // keeps the lane full with the new payload. Empty lanes keep their data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= '0;
            r_data <= '0;
        end else begin
            for (int k = 0; k < c_LANES; k++) begin
                if (w_load[k]) begin
                    r_data[k] <= in_data;
                    r_full[k] <= 1'b1;
                end else if (out_ready[k]) begin
                    r_full[k] <= 1'b0;
                end
            end
        end
    end

    // Free-running count of accepted beats, wrapping modulo 2^16.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat_cnt <= '0;
        end else if (w_accept) begin
            r_beat_cnt <= r_beat_cnt + 16'd1;
        end
    end

    // The packed [lane][bit] layout places lane k at [k*DW +: DW].
    assign out_valid = r_full;
    assign out_data  = r_data;
    assign busy      = |r_full;
    assign beat_cnt  = r_beat_cnt;

endmodule
`default_nettype wire

// File: tb/tb_demux_1x16.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux_1x16
// Description : Self-checking bench for demux_1x16: directed scenarios plus
//               randomized traffic compared against a lane-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_1x16;

    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_sel;
    logic [DW-1:0]     in_data;
    logic [15:0]       out_valid;
    logic [15:0]       out_ready;
    logic [16*DW-1:0]  out_data;
    logic              busy;
    logic [15:0]       beat_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: one slot per lane plus a beat counter.
    bit            m_full [16];
    logic [DW-1:0] m_data [16];
    logic [15:0]   m_cnt;

    demux_1x16 #(.DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .beat_cnt  (beat_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] lane(input int k);
        return out_data[k*DW +: DW];
    endfunction

    // One clock: check in_ready against the model, advance model across the
    // edge, then check all registered outputs.
    task automatic step();
        logic         exp_rdy;
        logic [15:0]  ev;
        logic [511:0] ed;
        #1;
        exp_rdy = !rst && (!m_full[in_sel] || out_ready[in_sel]);
        chk("in_ready", in_ready, exp_rdy);
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < 16; k++) begin
                m_full[k] = 0;
                m_data[k] = '0;
            end
            m_cnt = '0;
        end else begin
            for (int k = 0; k < 16; k++)
                if (m_full[k] && out_ready[k]) m_full[k] = 0;
            if (in_valid && exp_rdy) begin
                m_full[in_sel] = 1;
                m_data[in_sel] = in_data;
                m_cnt          = m_cnt + 16'd1;
            end
        end
        #1;
        ev = '0;
        ed = '0;
        for (int k = 0; k < 16; k++) begin
            ev[k]           = m_full[k];
            ed[k*DW +: DW]  = m_data[k];
        end
        chk("out_valid", out_valid, ev);
        chk("out_data", out_data, ed);
        chk("beat_cnt", beat_cnt, m_cnt);
        chk("busy", busy, (ev != 16'h0));
    endtask

    initial begin
        for (int k = 0; k < 16; k++) begin
            m_full[k] = 0;
            m_data[k] = '0;
        end
        m_cnt = '0;

        // Reset held two cycles with a beat offered on lane 3.
        rst = 1'b1; in_valid = 1'b1; in_sel = 4'd3; in_data = $urandom; out_ready = '0;
        step();
        chk("rst_in_ready", in_ready, 1'b0);
        step();
        rst = 1'b0; in_valid = 1'b0;
        step();
        chk("rst_out_valid", out_valid, 16'h0000);
        chk("rst_beat_cnt", beat_cnt, 16'h0000);

        // Single route to lane 5, then hold for three cycles.
        in_valid = 1'b1; in_sel = 4'd5; in_data = 32'hDEADBEEF; out_ready = '0;
        step();
        chk("route_valid", out_valid, 16'h0020);
        chk("route_data", lane(5), 32'hDEADBEEF);
        chk("route_cnt", beat_cnt, 16'd1);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_data", lane(5), 32'hDEADBEEF);
        end

        // Backpressure on lane 5 must not stall a beat for lane 9.
        in_valid = 1'b1; in_sel = 4'd5; in_data = 32'h55555555;
        #1;
        chk("bp_stall", in_ready, 1'b0);
        step();
        in_sel = 4'd9; in_data = 32'h99999999;
        step();
        chk("bp_other_valid", out_valid, 16'h0220);
        chk("bp_hold5", lane(5), 32'hDEADBEEF);

        // Drain all, then same-edge drain+load on lane 2.
        in_valid = 1'b0; out_ready = 16'hFFFF;
        step();
        in_valid = 1'b1; in_sel = 4'd2; in_data = 32'h11111111; out_ready = '0;
        step();
        out_ready = 16'h0004; in_data = 32'h22222222;
        #1;
        chk("dl_ready", in_ready, 1'b1);
        step();
        chk("dl_valid2", out_valid[2], 1'b1);
        chk("dl_data2", lane(2), 32'h22222222);
        in_valid = 1'b0; out_ready = '0;
        step();

        // Sweep every lane at full rate with all sinks ready.
        out_ready = 16'hFFFF;
        for (int k = 0; k < 16; k++) begin
            in_valid = 1'b1; in_sel = 4'(k); in_data = DW'(k);
            step();
            chk("sweep_lane", lane(k), DW'(k));
        end
        in_valid = 1'b0;
        step();
        step();
        chk("sweep_idle", busy, 1'b0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 49) == 0);
            in_valid  = $urandom_range(0, 3) != 0;
            in_sel    = 4'($urandom_range(0, 15));
            in_data   = $urandom;
            out_ready = 16'($urandom);
            step();
        end

        // Counter wrap: exactly 65536 beats from reset at full throughput.
        rst = 1'b1; in_valid = 1'b0; out_ready = 16'hFFFF;
        step();
        rst = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            in_sel  = 4'($urandom_range(0, 15));
            in_data = $urandom;
            step();
        end
        chk("wrap_cnt", beat_cnt, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
